// File: rtl/hdd_pkg.sv
// Shared definitions for the ProDOS HDD card and its host-side block server.
package hdd_pkg;

  localparam int unsigned HDD_BLOCK_BYTES = 512;
  localparam int unsigned HDD_CNT_W       = $clog2(HDD_BLOCK_BYTES);
  localparam logic [HDD_CNT_W-1:0] HDD_LAST_BYTE = HDD_CNT_W'(HDD_BLOCK_BYTES - 1);

  // ProDOS block-device command codes and status returns, as seen by the card
  localparam logic [7:0] PRODOS_CMD_STATUS  = 8'h00;
  localparam logic [7:0] PRODOS_CMD_READ    = 8'h01;
  localparam logic [7:0] PRODOS_CMD_WRITE   = 8'h02;
  localparam logic [7:0] PRODOS_CMD_FORMAT  = 8'h03;

  localparam logic [7:0] PRODOS_STAT_OK        = 8'h00;
  localparam logic [7:0] PRODOS_STAT_IO_ERROR  = 8'h27;
  localparam logic [7:0] PRODOS_STAT_NO_DEVICE = 8'h28;
  localparam logic [7:0] PRODOS_STAT_WRITE_PROT = 8'h2B;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_WR_REQ,
    ST_WR_ADDR,
    ST_WR_WAIT,
    ST_WR_LOAD,
    ST_WR_DATA,
    ST_FINISH
  } hdd_state_e;

endpackage

// File: rtl/hdd_watchdog.sv
// No-progress watchdog: counts enabled cycles since the last clear and
// flags the (2^TIMEOUT_W-1)th such cycle.
module hdd_watchdog #(
  parameter int unsigned TIMEOUT_W = 24
) (
  input  logic CLK_14M,
  input  logic RESET,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] TERM = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  // Terminal value is one short of all-ones so the flag rises during the
  // last counted cycle rather than one cycle later.
  assign expired = enable && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK_14M) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hdd_block_server.sv
// Host-side responder for the ProDOS HDD card: moves one 512-byte block
// between the host byte stream and the card's sector buffer.
module hdd_block_server
  import hdd_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = 24,
  parameter logic [31:0] LBA_BASE  = 32'h0
) (
  input  logic        CLK_14M,
  input  logic        RESET,
  input  logic        hdd_read,
  input  logic        hdd_write,
  input  logic [15:0] sector,
  input  logic        hdd_mounted,
  output logic [8:0]  ram_addr,
  output logic [7:0]  ram_di,
  output logic        ram_we,
  input  logic [7:0]  ram_do,
  output logic        busy,
  output logic        error,
  output logic [31:0] host_lba,
  output logic        host_rd_req,
  output logic        host_wr_req,
  input  logic        host_ack,
  input  logic [7:0]  host_rx_data,
  input  logic        host_rx_valid,
  output logic [7:0]  host_tx_data,
  output logic        host_tx_valid,
  input  logic        host_tx_ready
);

  hdd_state_e state_q, state_d;

  logic                 rd_q, wr_q;
  logic [HDD_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]          lba_q, lba_d;
  logic                 rd_req_q, rd_req_d;
  logic                 wr_req_q, wr_req_d;
  logic [8:0]           ram_addr_q, ram_addr_d;
  logic [7:0]           ram_di_q, ram_di_d;
  logic                 ram_we_q, ram_we_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 busy_q, busy_d;
  logic                 error_q, error_d;

  logic rd_edge, wr_edge;
  logic progress;
  logic wd_clear, wd_enable, wd_expired;

  assign rd_edge   = hdd_read  && !rd_q;
  assign wr_edge   = hdd_write && !wr_q;
  assign wd_enable = (state_q != ST_IDLE) && (state_q != ST_FINISH);

  hdd_watchdog #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_watchdog (
    .CLK_14M (CLK_14M),
    .RESET   (RESET),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lba_d      = lba_q;
    rd_req_d   = rd_req_q;
    wr_req_d   = wr_req_q;
    ram_addr_d = ram_addr_q;
    ram_di_d   = ram_di_q;
    ram_we_d   = 1'b0;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    error_d    = 1'b0;
    progress   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hdd_mounted && (rd_edge || wr_edge)) begin
          lba_d  = LBA_BASE + {16'h0000, sector};
          cnt_d  = '0;
          busy_d = 1'b1;
          if (rd_edge) begin
            rd_req_d = 1'b1;
            state_d  = ST_RD_REQ;
          end else begin
            wr_req_d = 1'b1;
            state_d  = ST_WR_REQ;
          end
        end
      end
      ST_RD_REQ: begin
        if (host_ack) begin
          progress = 1'b1;
          rd_req_d = 1'b0;
          state_d  = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (host_rx_valid) begin
          progress   = 1'b1;
          ram_addr_d = cnt_q;
          ram_di_d   = host_rx_data;
          ram_we_d   = 1'b1;
          if (cnt_q == HDD_LAST_BYTE) begin
            state_d = ST_FINISH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_WR_REQ: begin
        if (host_ack) begin
          progress = 1'b1;
          wr_req_d = 1'b0;
          state_d  = ST_WR_ADDR;
        end
      end
      ST_WR_ADDR: begin
        ram_addr_d = cnt_q;
        state_d    = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        state_d = ST_WR_LOAD;
      end
      ST_WR_LOAD: begin
        tx_data_d  = ram_do;
        tx_valid_d = 1'b1;
        state_d    = ST_WR_DATA;
      end
      ST_WR_DATA: begin
        if (tx_valid_q && host_tx_ready) begin
          progress   = 1'b1;
          tx_valid_d = 1'b0;
          if (cnt_q == HDD_LAST_BYTE) begin
            state_d = ST_FINISH;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = ST_WR_ADDR;
          end
        end
      end
      ST_FINISH: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort only while stalled; a same-cycle handshake or scheduled state
    // advance takes priority over the timeout.
    if (wd_expired && !progress && (state_d == state_q)) begin
      state_d    = ST_IDLE;
      rd_req_d   = 1'b0;
      wr_req_d   = 1'b0;
      tx_valid_d = 1'b0;
      busy_d     = 1'b0;
      error_d    = 1'b1;
    end

    wd_clear = (state_d != state_q) || progress;
  end

  always_ff @(posedge CLK_14M) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      cnt_q      <= '0;
      lba_q      <= '0;
      rd_req_q   <= 1'b0;
      wr_req_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_di_q   <= '0;
      ram_we_q   <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= hdd_read;
      wr_q       <= hdd_write;
      cnt_q      <= cnt_d;
      lba_q      <= lba_d;
      rd_req_q   <= rd_req_d;
      wr_req_q   <= wr_req_d;
      ram_addr_q <= ram_addr_d;
      ram_di_q   <= ram_di_d;
      ram_we_q   <= ram_we_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
    end
  end

  assign ram_addr      = ram_addr_q;
  assign ram_di        = ram_di_q;
  assign ram_we        = ram_we_q;
  assign busy          = busy_q;
  assign error         = error_q;
  assign host_lba      = lba_q;
  assign host_rd_req   = rd_req_q;
  assign host_wr_req   = wr_req_q;
  assign host_tx_data  = tx_data_q;
  assign host_tx_valid = tx_valid_q;

endmodule
